// File: rtl/i2lbs_scan_ctrl.sv
// Window-scan controller: streams resized pixels into the line buffer, stalls at every
// stride-aligned window origin for one classifier inspection, and queues positive origins.
module i2lbs_scan_ctrl #(
  parameter int DATA_WIDTH_12   = 12,
  parameter int FRAME_WIDTH     = 10,
  parameter int FRAME_HEIGHT    = 10,
  parameter int INTEGRAL_WIDTH  = 3,
  parameter int INTEGRAL_HEIGHT = 3,
  parameter int STRIDE_X        = 1,
  parameter int STRIDE_Y        = 1,
  parameter int CAND_FIFO_DEPTH = 4,
  parameter int INSPECT_TIMEOUT = 1023
) (
  input  logic                     clk_fpga,
  input  logic                     reset_fpga,
  input  logic                     start,
  input  logic                     pixel_valid,
  output logic                     o_pixel_ready,
  output logic                     o_buf_wen,
  output logic                     o_inspect_start,
  output logic [DATA_WIDTH_12-1:0] o_win_x,
  output logic [DATA_WIDTH_12-1:0] o_win_y,
  input  logic                     inspect_done,
  input  logic                     candidate,
  output logic                     o_cand_valid,
  input  logic                     cand_ready,
  output logic [DATA_WIDTH_12-1:0] o_cand_x,
  output logic [DATA_WIDTH_12-1:0] o_cand_y,
  output logic                     o_overflow,
  output logic                     o_timeout,
  output logic                     o_frame_done,
  output logic                     o_busy
);
  localparam int W   = DATA_WIDTH_12;
  localparam int AW  = $clog2(CAND_FIFO_DEPTH);
  localparam int WDW = $clog2(INSPECT_TIMEOUT + 1);

  localparam logic [W-1:0]   COL_LAST  = W'(FRAME_WIDTH - 1);
  localparam logic [W-1:0]   ROW_LAST  = W'(FRAME_HEIGHT - 1);
  localparam logic [W-1:0]   COL_MIN   = W'(INTEGRAL_WIDTH - 1);
  localparam logic [W-1:0]   ROW_MIN   = W'(INTEGRAL_HEIGHT - 1);
  localparam logic [W-1:0]   PHX_LAST  = W'(STRIDE_X - 1);
  localparam logic [W-1:0]   PHY_LAST  = W'(STRIDE_Y - 1);
  // Phase of column/row 0 chosen so that phase 0 lands exactly on stride-aligned origins.
  localparam logic [W-1:0]   PHX_INIT  = W'((STRIDE_X - ((INTEGRAL_WIDTH - 1) % STRIDE_X)) % STRIDE_X);
  localparam logic [W-1:0]   PHY_INIT  = W'((STRIDE_Y - ((INTEGRAL_HEIGHT - 1) % STRIDE_Y)) % STRIDE_Y);
  localparam logic [WDW-1:0] WD_FIRST  = WDW'(1);
  localparam logic [WDW-1:0] WD_LAST   = WDW'(INSPECT_TIMEOUT);
  localparam logic [AW:0]    FIFO_FULL = (AW + 1)'(CAND_FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_INSPECT, S_DONE} state_t;

  state_t                            state_q, state_d;
  logic [W-1:0]                      col_q, col_d, row_q, row_d, phx_q, phx_d, phy_q, phy_d;
  logic [W-1:0]                      win_x_q, win_x_d, win_y_q, win_y_d;
  logic [WDW-1:0]                    wd_q, wd_d;
  logic                              last_q, last_d, timeout_q, timeout_d, overflow_q, overflow_d;
  logic [CAND_FIFO_DEPTH-1:0][W-1:0] mem_x_q, mem_x_d, mem_y_q, mem_y_d;
  logic [AW-1:0]                     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]                       cnt_q, cnt_d;
  logic [W-1:0]                      head_x_q, head_x_d, head_y_q, head_y_d;
  logic                              accept, last_pix, win_hit, push, pop, do_push;

  assign o_pixel_ready   = (state_q == S_STREAM);
  assign o_buf_wen       = pixel_valid & o_pixel_ready;
  assign o_inspect_start = (state_q == S_INSPECT) && (wd_q == WD_FIRST);
  assign o_win_x         = win_x_q;
  assign o_win_y         = win_y_q;
  assign o_cand_valid    = (cnt_q != '0);
  assign o_cand_x        = head_x_q;
  assign o_cand_y        = head_y_q;
  assign o_overflow      = overflow_q;
  assign o_timeout       = timeout_q;
  assign o_frame_done    = (state_q == S_DONE);
  assign o_busy          = (state_q != S_IDLE);

  assign accept   = o_buf_wen;
  assign last_pix = (col_q == COL_LAST) && (row_q == ROW_LAST);
  assign win_hit  = (col_q >= COL_MIN) && (row_q >= ROW_MIN) && (phx_q == '0) && (phy_q == '0);
  assign pop      = o_cand_valid & cand_ready;

  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    row_d      = row_q;
    phx_d      = phx_q;
    phy_d      = phy_q;
    win_x_d    = win_x_q;
    win_y_d    = win_y_q;
    wd_d       = wd_q;
    last_d     = last_q;
    timeout_d  = timeout_q;
    overflow_d = overflow_q;
    push       = 1'b0;
    case (state_q)
      S_IDLE: if (start) begin
        state_d    = S_STREAM;
        col_d      = '0;
        row_d      = '0;
        phx_d      = PHX_INIT;
        phy_d      = PHY_INIT;
        win_x_d    = '0;
        win_y_d    = '0;
        wd_d       = '0;
        last_d     = 1'b0;
        timeout_d  = 1'b0;
        overflow_d = 1'b0;
      end
      S_STREAM: if (accept) begin
        if (col_q == COL_LAST) begin
          col_d = '0;
          phx_d = PHX_INIT;
          row_d = row_q + 1'b1;
          phy_d = (phy_q == PHY_LAST) ? '0 : phy_q + 1'b1;
        end else begin
          col_d = col_q + 1'b1;
          phx_d = (phx_q == PHX_LAST) ? '0 : phx_q + 1'b1;
        end
        if (win_hit) begin
          win_x_d = col_q - COL_MIN;
          win_y_d = row_q - ROW_MIN;
          last_d  = last_pix;
          wd_d    = WD_FIRST;
          state_d = S_INSPECT;
        end else if (last_pix) begin
          state_d = S_DONE;
        end
      end
      S_INSPECT: begin
        // A done on the start cycle belongs to no window yet; a done on the final watchdog cycle still counts.
        if (inspect_done && (wd_q != WD_FIRST)) begin
          push    = candidate;
          state_d = last_q ? S_DONE : S_STREAM;
        end else if (wd_q == WD_LAST) begin
          timeout_d = 1'b1;
          state_d   = last_q ? S_DONE : S_STREAM;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    do_push  = push && ((cnt_q != FIFO_FULL) || pop);
    if (push && !do_push) overflow_d = 1'b1;
    mem_x_d  = mem_x_q;
    mem_y_d  = mem_y_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) begin
      mem_x_d[wr_ptr_q] = win_x_q;
      mem_y_d[wr_ptr_q] = win_y_q;
      wr_ptr_d          = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    if (do_push && !pop)      cnt_d = cnt_q + 1'b1;
    else if (!do_push && pop) cnt_d = cnt_q - 1'b1;
    // Head is registered so it keeps the last popped entry once the queue runs dry.
    head_x_d = head_x_q;
    head_y_d = head_y_q;
    if (cnt_d != '0) begin
      head_x_d = mem_x_d[rd_ptr_d];
      head_y_d = mem_y_d[rd_ptr_d];
    end
  end

  always_ff @(posedge clk_fpga or posedge reset_fpga) begin
    if (reset_fpga) begin
      state_q    <= S_IDLE;
      col_q      <= '0;
      row_q      <= '0;
      phx_q      <= '0;
      phy_q      <= '0;
      win_x_q    <= '0;
      win_y_q    <= '0;
      wd_q       <= '0;
      last_q     <= 1'b0;
      timeout_q  <= 1'b0;
      overflow_q <= 1'b0;
      mem_x_q    <= '0;
      mem_y_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      head_x_q   <= '0;
      head_y_q   <= '0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      row_q      <= row_d;
      phx_q      <= phx_d;
      phy_q      <= phy_d;
      win_x_q    <= win_x_d;
      win_y_q    <= win_y_d;
      wd_q       <= wd_d;
      last_q     <= last_d;
      timeout_q  <= timeout_d;
      overflow_q <= overflow_d;
      mem_x_q    <= mem_x_d;
      mem_y_q    <= mem_y_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      head_x_q   <= head_x_d;
      head_y_q   <= head_y_d;
    end
  end
endmodule

// File: tb/tb_i2lbs_scan_ctrl.sv
// Bench for i2lbs_scan_ctrl: instance 0 is a 4x4 frame (depth 2, timeout 8), instance 1 a
// 5x5 frame with stride 2; a queue-level model predicts windows, stalls and candidate traffic.
module tb_i2lbs_scan_ctrl;
  logic clk = 1'b0;
  logic rst;
  logic [1:0] start_s, pv_s, done_s, cand_s, cr_s;
  logic [1:0] rdy, wen, ist, cv, ovf, tmo, fd, bsy;
  logic [1:0][11:0] wx, wy, cx, cy;
  int checks = 0;
  int fails  = 0;
  logic [23:0] exp_q[$];

  always #5 clk = ~clk;

  i2lbs_scan_ctrl #(.FRAME_WIDTH(4), .FRAME_HEIGHT(4), .INTEGRAL_WIDTH(3), .INTEGRAL_HEIGHT(3),
    .STRIDE_X(1), .STRIDE_Y(1), .CAND_FIFO_DEPTH(2), .INSPECT_TIMEOUT(8)) dut_a (
    .clk_fpga(clk), .reset_fpga(rst), .start(start_s[0]), .pixel_valid(pv_s[0]),
    .o_pixel_ready(rdy[0]), .o_buf_wen(wen[0]), .o_inspect_start(ist[0]), .o_win_x(wx[0]),
    .o_win_y(wy[0]), .inspect_done(done_s[0]), .candidate(cand_s[0]), .o_cand_valid(cv[0]),
    .cand_ready(cr_s[0]), .o_cand_x(cx[0]), .o_cand_y(cy[0]), .o_overflow(ovf[0]),
    .o_timeout(tmo[0]), .o_frame_done(fd[0]), .o_busy(bsy[0]));

  i2lbs_scan_ctrl #(.FRAME_WIDTH(5), .FRAME_HEIGHT(5), .INTEGRAL_WIDTH(3), .INTEGRAL_HEIGHT(3),
    .STRIDE_X(2), .STRIDE_Y(2), .CAND_FIFO_DEPTH(4), .INSPECT_TIMEOUT(6)) dut_b (
    .clk_fpga(clk), .reset_fpga(rst), .start(start_s[1]), .pixel_valid(pv_s[1]),
    .o_pixel_ready(rdy[1]), .o_buf_wen(wen[1]), .o_inspect_start(ist[1]), .o_win_x(wx[1]),
    .o_win_y(wy[1]), .inspect_done(done_s[1]), .candidate(cand_s[1]), .o_cand_valid(cv[1]),
    .cand_ready(cr_s[1]), .o_cand_x(cx[1]), .o_cand_y(cy[1]), .o_overflow(ovf[1]),
    .o_timeout(tmo[1]), .o_frame_done(fd[1]), .o_busy(bsy[1]));

  function automatic int fw(input int k);    return (k == 0) ? 4 : 5; endfunction
  function automatic int fh(input int k);    return (k == 0) ? 4 : 5; endfunction
  function automatic int sx(input int k);    return (k == 0) ? 1 : 2; endfunction
  function automatic int sy(input int k);    return (k == 0) ? 1 : 2; endfunction
  function automatic int depth(input int k); return (k == 0) ? 2 : 4; endfunction
  function automatic int tlim(input int k);  return (k == 0) ? 8 : 6; endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs(input int k);
    start_s[k] = 1'b0; pv_s[k] = 1'b0; done_s[k] = 1'b0; cand_s[k] = 1'b0; cr_s[k] = 1'b0;
  endtask

  // cr_pct above 100 means: assert cand_ready only in cycles that also push a candidate.
  task automatic run_frame(input int k, input int pv_pct, input int cand_pct, input int cr_pct,
                           input int dmin, input int dmax);
    int wxs[$];
    int wys[$];
    int widx, wen_cnt, off, dly, end_off, fd_cnt, nf, cur_x, cur_y;
    bit in_insp, honoured, cflag, trig_last, exp_ovf, exp_to, push, pop, fin;
    for (int r = 0; r < fh(k); r++)
      for (int c = 0; c < fw(k); c++)
        if (c >= 2 && r >= 2 && (c - 2) % sx(k) == 0 && (r - 2) % sy(k) == 0) begin
          wxs.push_back(c - 2);
          wys.push_back(r - 2);
        end
    widx = 0; wen_cnt = 0; off = 0; dly = 0; end_off = 0; fd_cnt = 0; cur_x = 0; cur_y = 0;
    in_insp = 0; honoured = 0; cflag = 0; trig_last = 0; exp_ovf = 0; exp_to = 0; fin = 0;
    for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
      @(negedge clk);
      if (cyc == 0) chk("idle_before_start", bsy[k], 0);
      if (in_insp && off == end_off + 1) begin
        in_insp = 0;
        if (trig_last) chk("done_after_last_window", fd[k], 1);
        else           chk("ready_after_inspect", rdy[k], 1);
      end
      if (ist[k]) begin
        chk("inspect_start_expected", {31'd0, (!in_insp && widx < wxs.size())}, 1);
        trig_last = 0;
        if (widx < wxs.size()) begin
          cur_x = wxs[widx];
          cur_y = wys[widx];
          chk("win_x", wx[k], cur_x);
          chk("win_y", wy[k], cur_y);
          nf = (cur_y + 2) * fw(k) + cur_x + 2;
          chk("pixels_before_stall", wen_cnt, nf + 1);
          trig_last = (nf == fw(k) * fh(k) - 1);
        end
        widx++;
        in_insp  = 1;
        off      = 0;
        dly      = $urandom_range(dmax, dmin);
        honoured = (dly <= tlim(k) - 1);
        end_off  = honoured ? dly : tlim(k) - 1;
        cflag    = ($urandom_range(99) < cand_pct);
      end
      if (in_insp) chk("ready_low_in_inspect", rdy[k], 0);
      if (fd[k]) begin
        fd_cnt++;
        fin = 1;
      end
      start_s[k] = (cyc == 0) || ($urandom_range(19) == 0);
      pv_s[k]    = ($urandom_range(99) < pv_pct);
      cr_s[k]    = (cr_pct > 100) ? 1'b0 : ($urandom_range(99) < cr_pct);
      done_s[k]  = 1'b0;
      cand_s[k]  = 1'b0;
      push       = 0;
      if (in_insp) begin
        if (off == 0) begin
          done_s[k] = 1'($urandom_range(1));
          cand_s[k] = 1'b1;
        end else if (off == dly) begin
          done_s[k] = 1'b1;
          cand_s[k] = cflag;
          push      = cflag;
        end
        if (cr_pct > 100 && push) cr_s[k] = 1'b1;
        if (!honoured && off == end_off) exp_to = 1;
      end
      #1;
      chk("buf_wen", wen[k], pv_s[k] & rdy[k]);
      if (wen[k]) wen_cnt++;
      chk("cand_valid", cv[k], exp_q.size() != 0);
      pop = (exp_q.size() != 0) && cr_s[k];
      if (pop) begin
        chk("cand_head", {cx[k], cy[k]}, exp_q[0]);
        void'(exp_q.pop_front());
      end
      if (push) begin
        if (exp_q.size() < depth(k)) exp_q.push_back({12'(cur_x), 12'(cur_y)});
        else exp_ovf = 1;
      end
      if (in_insp) off++;
    end
    chk("frame_done_once", fd_cnt, 1);
    chk("pixels_written", wen_cnt, fw(k) * fh(k));
    chk("window_count", widx, wxs.size());
    chk("overflow_flag", ovf[k], exp_ovf);
    chk("timeout_flag", tmo[k], exp_to);
    @(negedge clk);
    idle_inputs(k);
    #1;
    chk("idle_after_frame", bsy[k], 0);
    chk("cand_valid_after_frame", cv[k], exp_q.size() != 0);
  endtask

  task automatic drain(input int k);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      idle_inputs(k);
      cr_s[k] = 1'b1;
      #1;
      chk("drain_valid", cv[k], exp_q.size() != 0);
      if (exp_q.size() != 0) begin
        chk("drain_head", {cx[k], cy[k]}, exp_q[0]);
        void'(exp_q.pop_front());
      end
    end
    @(negedge clk);
    cr_s[k] = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    idle_inputs(0);
    idle_inputs(1);
    #2 rst = 1'b1;
    pv_s[0] = 1'b1;
    #1;
    chk("rst_ready", rdy[0], 0);
    chk("rst_wen", wen[0], 0);
    chk("rst_busy", bsy[0], 0);
    chk("rst_inspect_start", ist[0], 0);
    chk("rst_cand_valid", cv[0], 0);
    chk("rst_overflow", ovf[0], 0);
    chk("rst_timeout", tmo[0], 0);
    chk("rst_frame_done", fd[0], 0);
    chk("rst_win", {wx[0], wy[0]}, 0);
    chk("rst_cand_head", {cx[0], cy[0]}, 0);
    chk("rst_busy_b", bsy[1], 0);
    repeat (2) @(negedge clk);
    pv_s[0] = 1'b0;
    rst = 1'b0;

    // 4x4 scan, done 3 cycles after each start, no candidates
    run_frame(0, 100, 0, 50, 3, 3);
    // 5x5 scan with stride 2
    run_frame(1, 100, 0, 50, 2, 2);
    // watchdog abort: done never arrives within the 8-cycle budget
    run_frame(0, 100, 100, 50, 100, 100);
    chk("t4_timeout", tmo[0], 1);
    chk("t4_fifo_empty", cv[0], 0);
    // every window positive, nobody popping: the 2-entry queue overflows
    run_frame(0, 100, 100, 0, 3, 3);
    chk("t3_head", {cx[0], cy[0]}, 24'h000000);
    chk("t3_valid", cv[0], 1);
    chk("t3_overflow", ovf[0], 1);
    // full queue, pop coincides with every push: no drop
    run_frame(0, 100, 100, 200, 3, 3);
    chk("t5_overflow", ovf[0], 0);
    chk("t5_head", {cx[0], cy[0]}, 24'h000001);
    chk("t5_valid", cv[0], 1);

    // reset in the middle of an inspection
    @(negedge clk);
    start_s[0] = 1'b1;
    pv_s[0]    = 1'b1;
    @(negedge clk);
    start_s[0] = 1'b0;
    for (int i = 0; i < 100 && !ist[0]; i++) @(negedge clk);
    chk("t6_in_inspect", ist[0], 1);
    rst = 1'b1;
    #1;
    chk("t6_ready", rdy[0], 0);
    chk("t6_wen", wen[0], 0);
    chk("t6_busy", bsy[0], 0);
    chk("t6_inspect_start", ist[0], 0);
    chk("t6_fifo_flushed", cv[0], 0);
    chk("t6_win", {wx[0], wy[0]}, 0);
    exp_q.delete();
    @(negedge clk);
    idle_inputs(0);
    rst = 1'b0;
    run_frame(0, 70, 50, 50, 1, 9);

    for (int f = 0; f < 4; f++) run_frame(0, 60, 50, 40, 1, 9);
    drain(0);
    for (int f = 0; f < 3; f++) run_frame(1, 60, 50, 40, 1, 7);
    drain(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
